// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 multiplexer family.
// Width default and select encoding used by the combinational and registered variants.
package mux_pkg;

    localparam int unsigned MUX_DEFAULT_WIDTH = 8;

    typedef enum logic {
        SEL_Q0 = 1'b0,
        SEL_Q1 = 1'b1
    } mux_sel_e;

endpackage

// File: rtl/mux_2to1_comb.sv
// Combinational 2:1 select with enable; output is all-zero when disabled.
// Usable on its own wherever no register boundary is wanted.
module mux_2to1_comb
    import mux_pkg::*;
#(
    parameter int unsigned n = MUX_DEFAULT_WIDTH
) (
    input  logic [n-1:0] q0,
    input  logic [n-1:0] q1,
    input  logic         sel,
    input  logic         en,
    output logic [n-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            // Plain two-way choice so an unknown select never infers storage.
            if (mux_sel_e'(sel) == SEL_Q1) begin
                y = q1;
            end else begin
                y = q0;
            end
        end
    end

endmodule

// File: rtl/mux_2to1_reg.sv
// Registered 2:1 multiplexer with enable: one-cycle latency, async active-low clear.
// Disable clears the output register rather than holding it.
module mux_2to1_reg
    import mux_pkg::*;
#(
    parameter int unsigned n = MUX_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] q0,
    input  logic [n-1:0] q1,
    input  logic         sel,
    input  logic         en,
    output logic [n-1:0] d
);

    logic [n-1:0] d_d;
    logic [n-1:0] d_q;

    mux_2to1_comb #(
        .n(n)
    ) u_comb (
        .q0 (q0),
        .q1 (q1),
        .sel(sel),
        .en (en),
        .y  (d_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign d = d_q;

endmodule

// File: tb/tb_mux_2to1_reg.sv
// Self-checking bench for mux_2to1_reg at n=8: vector table, corner sequences,
// exhaustive sweep and random stimulus against a behavioural model.
module tb_mux_2to1_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] q0;
    logic [7:0] q1;
    logic       sel;
    logic       en;
    logic [7:0] d;

    int vectors;
    int miscompares;

    mux_2to1_reg #(
        .n(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .q0   (q0),
        .q1   (q1),
        .sel  (sel),
        .en   (en),
        .d    (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic       sel;
        logic       en;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[9];

    // Reference: pick the word named by sel from a two-entry array, or zero when disabled.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input logic e);
        logic [7:0] pick[2];
        pick[0] = a;
        pick[1] = b;
        return e ? pick[s] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: d=%02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic e);
        q0  = a;
        q1  = b;
        sel = s;
        en  = e;
    endtask

    // Advance through one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_v;
    logic [7:0] iv;

    initial begin
        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{8'h5A, 8'hA5, 1'b0, 1'b1, 8'h5A, "sel0"};
        tbl[1] = '{8'h5A, 8'hA5, 1'b1, 1'b1, 8'hA5, "sel1"};
        tbl[2] = '{8'h5A, 8'hA5, 1'b0, 1'b1, 8'h5A, "toggle0"};
        tbl[3] = '{8'h5A, 8'hA5, 1'b1, 1'b1, 8'hA5, "toggle1"};
        tbl[4] = '{8'h3C, 8'hC3, 1'b0, 1'b0, 8'h00, "dis_sel0"};
        tbl[5] = '{8'h3C, 8'hC3, 1'b1, 1'b0, 8'h00, "dis_sel1"};
        tbl[6] = '{8'h3C, 8'hC3, 1'b0, 1'b1, 8'h3C, "reenable"};
        tbl[7] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, "sel1_zero"};
        tbl[8] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, "sel0_ones"};

        // Load a nonzero value first so the asynchronous clear is observable.
        rst_n = 1'b1;
        drive(8'h00, 8'hFF, 1'b1, 1'b1);
        tick();
        check("preload", d, 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_async", d, 8'h00);
        tick();
        check("reset_hold1", d, 8'h00);
        tick();
        check("reset_hold2", d, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // d must not move before the sampling edge.
        drive(8'h5A, 8'hA5, 1'b0, 1'b1);
        #1;
        check("pre_edge", d, 8'h00);
        tick();

        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].q0, tbl[k].q1, tbl[k].sel, tbl[k].en);
            tick();
            check(tbl[k].name, d, tbl[k].exp);
        end

        // Input wiggles between edges have no effect; only the value at the edge counts.
        drive(8'h11, 8'h99, 1'b0, 1'b1);
        tick();
        check("between_base", d, 8'h11);
        q0 = 8'h22;
        @(negedge clk);
        q0  = 8'h33;
        sel = 1'b1;
        #1;
        check("between_hold", d, 8'h11);
        sel = 1'b0;
        tick();
        check("between_last", d, 8'h33);

        // Reset mid-operation while enabled, then the first edge after release loads.
        drive(8'h5A, 8'hA5, 1'b1, 1'b1);
        tick();
        check("mid_pre", d, 8'hA5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset", d, 8'h00);
        sel = 1'b0;
        tick();
        check("mid_reset_edge", d, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_release", d, 8'h5A);

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            drive(iv, ~iv, ~iv[0], iv[1]);
            exp_v = model(iv, ~iv, ~iv[0], iv[1]);
            tick();
            check("sweep", d, exp_v);
        end

        // Random stimulus with occasional asynchronous resets.
        for (int r = 0; r < 300; r++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            exp_v = model(q0, q1, sel, en);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("rand_reset", d, 8'h00);
                exp_v = 8'h00;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
            check("random", d, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
